// File: rtl/compare_pkg.sv
// rtl/compare_pkg.sv - shared cascade codes, FSM encoding and tie-break helper for the serial comparator
package compare_pkg;

  // One-hot {gt,lt,eq} cascade codes shared with the 4-bit slice chain
  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_LT   = 3'b010;
  localparam logic [2:0] CMP_EQ   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } cmpState_e;

  // Legal one-hot tie codes pass through; anything malformed collapses to "equal"
  function automatic logic [2:0] resolveTie(input logic [2:0] code);
    case (code)
      CMP_GT, CMP_LT, CMP_EQ: return code;
      default:                return CMP_EQ;
    endcase
  endfunction

endpackage

// File: rtl/compare_nib.sv
// rtl/compare_nib.sv - combinational 4-bit magnitude compare without cascade input
module compare_nib (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt,
  output logic       lt,
  output logic       eq
);

  // Plain unsigned compare of one nibble pair
  always_comb begin
    gt = (a > b);
    lt = (a < b);
    eq = (a == b);
  end

endmodule

// File: rtl/compare_serial_msb.sv
// rtl/compare_serial_msb.sv - multi-cycle wide comparator scanning one nibble per clock, MSB first
module compare_serial_msb
  import compare_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic [2:0]       iData,
  output logic             oBusy,
  output logic             oDone,
  output logic [2:0]       oData
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] IDX_MSB = IDXW'(NIB - 1);

  cmpState_e        state;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [2:0]       regC;
  logic [IDXW-1:0]  idx;

  logic [3:0] nibA;
  logic [3:0] nibB;
  logic       nibGt;
  logic       nibLt;
  logic       nibEq;

  // Select the nibble pair currently under inspection from the latched operands
  always_comb begin
    nibA = regA[{idx, 2'b00} +: 4];
    nibB = regB[{idx, 2'b00} +: 4];
  end

  compare_nib uNib (
    .a  (nibA),
    .b  (nibB),
    .gt (nibGt),
    .lt (nibLt),
    .eq (nibEq)
  );

  // Control FSM with registered busy/done/result; reset drops any scan without a done pulse
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= S_IDLE;
      oBusy <= 1'b0;
      oDone <= 1'b0;
      oData <= CMP_NONE;
      regA  <= '0;
      regB  <= '0;
      regC  <= CMP_NONE;
      idx   <= '0;
    end else begin
      oDone <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (iStart) begin
            regA  <= iData_a;
            regB  <= iData_b;
            regC  <= iData;
            idx   <= IDX_MSB;
            oBusy <= 1'b1;
            state <= S_SCAN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SCAN: begin
          if (nibGt) begin
            oData <= CMP_GT;
            oBusy <= 1'b0;
            oDone <= 1'b1;
            state <= S_DONE;
          end else if (nibLt) begin
            oData <= CMP_LT;
            oBusy <= 1'b0;
            oDone <= 1'b1;
            state <= S_DONE;
          end else if (nibEq && (idx != '0)) begin
            idx <= idx - 1'b1;
          end else begin
            // Every nibble matched: the cascade input decides
            oData <= resolveTie(regC);
            oBusy <= 1'b0;
            oDone <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          oBusy <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compare_serial_msb.sv
// tb/tb_compare_serial_msb.sv - self-checking bench for the serial MSB-first comparator
module tb_compare_serial_msb;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             iClk = 1'b0;
  logic             iRst;
  logic             iStart;
  logic [WIDTH-1:0] iData_a;
  logic [WIDTH-1:0] iData_b;
  logic [2:0]       iData;
  logic             oBusy;
  logic             oDone;
  logic [2:0]       oData;

  int checks = 0;
  int errors = 0;

  compare_serial_msb #(.WIDTH(WIDTH)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iStart  (iStart),
    .iData_a (iData_a),
    .iData_b (iData_b),
    .iData   (iData),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oData   (oData)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] refResult(input int unsigned a, input int unsigned b,
                                           input logic [2:0] tie);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    if (tie == 3'b100 || tie == 3'b010 || tie == 3'b001) return tie;
    return 3'b001;
  endfunction

  // Nibbles examined = nibbles from the top down to and including the highest differing one
  function automatic int refNibbles(input int unsigned a, input int unsigned b);
    int unsigned x;
    int top;
    x = a ^ b;
    if (x == 0) return NIB;
    top = 0;
    for (int p = 0; p < WIDTH; p++) if ((x >> p) & 1) top = p;
    return NIB - (top / 4);
  endfunction

  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] tie);
    iData_a = a;
    iData_b = b;
    iData   = tie;
    iStart  = 1'b1;
  endtask

  // Walks edges from the accepting edge (edge 1) until oDone; optional stray start pulse during SCAN
  task automatic finishOp(input int expM, input logic [2:0] expD, input string tag, input int pulseAt);
    int busyCnt = 0;
    int doneAt  = 0;
    for (int cyc = 1; cyc <= NIB + 4 && doneAt == 0; cyc++) begin
      @(posedge iClk); #1;
      if (cyc == 1) iStart = 1'b0;
      if (pulseAt != 0 && cyc == pulseAt) begin
        iStart  = 1'b1;
        iData_a = WIDTH'($urandom);
        iData_b = WIDTH'($urandom);
        iData   = 3'($urandom);
      end
      if (pulseAt != 0 && cyc == pulseAt + 1) iStart = 1'b0;
      if (oDone) doneAt = cyc;
      else if (oBusy) busyCnt++;
    end
    check({tag, " latency"}, doneAt, expM + 1);
    check({tag, " busy cycles"}, busyCnt, expM);
    check({tag, " result"}, oData, expD);
    check({tag, " busy at done"}, oBusy, 1'b0);
  endtask

  task automatic idleAfter(input logic [2:0] expD, input string tag);
    @(posedge iClk); #1;
    check({tag, " done one cycle"}, oDone, 1'b0);
    check({tag, " idle busy"}, oBusy, 1'b0);
    check({tag, " result held"}, oData, expD);
  endtask

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       tie;
    logic [2:0]       expD;
    logic             pending;
    int               sawDone;

    iRst = 1'b1; iStart = 1'b0; iData_a = '0; iData_b = '0; iData = 3'b000;
    @(posedge iClk); @(posedge iClk); #1;
    iRst = 1'b0;
    check("reset oData", oData, 3'b000);
    check("reset oBusy", oBusy, 1'b0);
    check("reset oDone", oDone, 1'b0);
    sawDone = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge iClk); #1;
      if (oDone || oBusy) sawDone++;
    end
    check("idle quiet", sawDone, 0);

    launch(16'hA000, 16'h9FFF, 3'b001);
    finishOp(1, 3'b100, "msb decides", 0);
    idleAfter(3'b100, "msb decides");

    launch(16'h1234, 16'h1235, 3'b100);
    finishOp(4, 3'b010, "lsb decides", 0);
    idleAfter(3'b010, "lsb decides");

    launch(16'hBEEF, 16'hBEEF, 3'b100);
    finishOp(NIB, 3'b100, "tie gt", 0);
    idleAfter(3'b100, "tie gt");
    launch(16'hBEEF, 16'hBEEF, 3'b010);
    finishOp(NIB, 3'b010, "tie lt", 0);
    idleAfter(3'b010, "tie lt");
    launch(16'hBEEF, 16'hBEEF, 3'b011);
    finishOp(NIB, 3'b001, "tie illegal", 0);
    idleAfter(3'b001, "tie illegal");

    // Stray start during SCAN is ignored; a start in the DONE cycle is accepted
    launch(16'h1234, 16'h1235, 3'b001);
    finishOp(4, 3'b010, "ignored start", 2);
    launch(16'h0001, 16'h0000, 3'b010);
    finishOp(4, 3'b100, "back to back", 0);
    idleAfter(3'b100, "back to back");

    // Reset in the second SCAN cycle aborts silently
    launch(16'h5555, 16'h5556, 3'b001);
    @(posedge iClk); #1;
    iStart = 1'b0;
    @(posedge iClk); #1;
    iRst = 1'b1;
    @(posedge iClk); #1;
    iRst = 1'b0;
    check("abort oData", oData, 3'b000);
    check("abort oBusy", oBusy, 1'b0);
    check("abort oDone", oDone, 1'b0);
    sawDone = 0;
    for (int i = 0; i < NIB + 3; i++) begin
      @(posedge iClk); #1;
      if (oDone) sawDone++;
    end
    check("abort no done", sawDone, 0);

    // Randomized operations, chained back-to-back at random
    pending = 1'b0;
    for (int n = 0; n < 40; n++) begin
      a = WIDTH'($urandom);
      case ($urandom_range(0, 2))
        0:       b = WIDTH'($urandom);
        1:       b = a;
        default: b = a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
      endcase
      tie  = 3'($urandom);
      expD = refResult(a, b, tie);
      launch(a, b, tie);
      finishOp(refNibbles(a, b), expD, $sformatf("rand%0d a=%h b=%h c=%b", n, a, b, tie), 0);
      if ($urandom_range(0, 1) == 0) idleAfter(expD, $sformatf("rand%0d", n));
    end
    if (pending) check("pending", pending, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
